// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared state encoding and direction constants for the counter controller
package counter_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } ctrl_state_t;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
endpackage

// File: rtl/counter_ctrl_cnt_core.sv
// cnt_core: load/step count register; load has priority over stepping
module cnt_core #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         dir,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb
    cnt_d = load ? load_val : en ? (dir ? cnt_q + W'(1) : cnt_q - W'(1)) : cnt_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign cnt = cnt_q;
endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: start/stop/pause sequencer with one-shot or periodic terminal count around cnt_core
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int   W       = 8,
  parameter logic DEF_DIR = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic         periodic,
  input  logic         dir,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         busy,
  output logic         done
);
  ctrl_state_t  state_q, state_d;
  logic [W-1:0] lim_q, lim_d;
  logic         dir_q, dir_d;
  logic         per_q, per_d;
  logic         done_q, done_d;
  logic         load, en;
  logic [W-1:0] load_val, start_val, term_val;

  assign start_val = (dir_q == DIR_UP) ? '0 : lim_q;
  assign term_val  = (dir_q == DIR_DN) ? '0 : lim_q;

  // Terminal compare is evaluated before any step, so the counter never wraps.
  always_comb begin
    state_d  = state_q;
    lim_d    = lim_q;
    dir_d    = dir_q;
    per_d    = per_q;
    done_d   = 1'b0;
    load     = 1'b0;
    en       = 1'b0;
    load_val = start_val;
    case (state_q)
      IDLE:
        if (start) begin
          lim_d    = limit;
          dir_d    = dir;
          per_d    = periodic;
          load     = 1'b1;
          load_val = (dir == DIR_UP) ? '0 : limit;
          state_d  = RUN;
        end
      RUN:
        if (stop) state_d = IDLE;
        else if (pause) state_d = HOLD;
        else if (cnt == term_val) begin
          done_d  = 1'b1;
          load    = per_q;
          state_d = per_q ? RUN : IDLE;
        end else en = 1'b1;
      HOLD:
        state_d = stop ? IDLE : pause ? HOLD : RUN;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      lim_q   <= '0;
      dir_q   <= DEF_DIR;
      per_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      dir_q   <= dir_d;
      per_q   <= per_d;
      done_q  <= done_d;
    end

  cnt_core #(.W(W)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .load_val(load_val),
    .en      (en),
    .dir     (dir_q),
    .cnt     (cnt)
  );

  assign busy = (state_q != IDLE);
  assign done = done_q;
endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed stimulus with hand-computed expectations for counter_ctrl
module tb_counter_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, periodic = 1'b0, dir = 1'b1;
  logic [7:0] limit = '0;
  logic [7:0] cnt;
  logic       busy, done;
  int         errors = 0;
  int         checks = 0;

  counter_ctrl #(.W(8), .DEF_DIR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .periodic(periodic), .dir(dir), .limit(limit), .cnt(cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [7:0] c, input logic b, input logic d);
    chk({tag, ".cnt"}, 32'(cnt), 32'(c));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
  endtask

  task automatic go(input logic d, input logic [7:0] l, input logic p);
    dir = d; limit = l; periodic = p; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #2;
    chk3("reset", 8'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    // one-shot up, limit 5
    go(1'b1, 8'd5, 1'b0);
    chk3("t1.start", 8'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk3("t1.run", 8'(i), 1'b1, 1'b0);
    end
    tick();
    chk3("t1.term", 8'd5, 1'b0, 1'b1);
    tick();
    chk3("t1.idle", 8'd5, 1'b0, 1'b0);
    // periodic down, limit 3
    go(1'b0, 8'd3, 1'b1);
    chk3("t2.start", 8'd3, 1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk3("t2.run", 8'(3 - (k % 4)), 1'b1, (k % 4) == 0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk3("t2.stop", 8'd3, 1'b0, 1'b0);
    // pause at 4 for four edges, then one resume edge before counting
    go(1'b1, 8'd10, 1'b0);
    repeat (4) tick();
    chk3("t3.at4", 8'd4, 1'b1, 1'b0);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk3("t3.hold", 8'd4, 1'b1, 1'b0);
    end
    pause = 1'b0;
    tick();
    chk3("t3.resume", 8'd4, 1'b1, 1'b0);
    for (int i = 5; i <= 10; i++) begin
      tick();
      chk3("t3.run", 8'(i), 1'b1, 1'b0);
    end
    tick();
    chk3("t3.term", 8'd10, 1'b0, 1'b1);
    // stop and pause together at 50
    go(1'b1, 8'd200, 1'b0);
    repeat (50) tick();
    chk3("t4.at50", 8'd50, 1'b1, 1'b0);
    stop = 1'b1; pause = 1'b1;
    tick();
    stop = 1'b0; pause = 1'b0;
    chk3("t4.stop", 8'd50, 1'b0, 1'b0);
    tick();
    chk3("t4.idle", 8'd50, 1'b0, 1'b0);
    go(1'b1, 8'd200, 1'b0);
    chk3("t4.restart", 8'd0, 1'b1, 1'b0);
    tick();
    chk3("t4.step", 8'd1, 1'b1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    // periodic limit 0: done every cycle
    go(1'b1, 8'd0, 1'b1);
    chk3("t5.start", 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk3("t5.lim0", 8'd0, 1'b1, 1'b1);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk3("t5.stop", 8'd0, 1'b0, 1'b0);
    // full-range one-shot up
    go(1'b1, 8'd255, 1'b0);
    repeat (255) tick();
    chk3("t5.at255", 8'd255, 1'b1, 1'b0);
    tick();
    chk3("t5.term255", 8'd255, 1'b0, 1'b1);
    tick();
    chk3("t5.after255", 8'd255, 1'b0, 1'b0);
    // start ignored in RUN, then async reset mid-run
    go(1'b1, 8'd20, 1'b0);
    repeat (7) tick();
    chk3("t6.at7", 8'd7, 1'b1, 1'b0);
    start = 1'b1; dir = 1'b0; limit = 8'd3;
    tick();
    chk3("t6.ignstart", 8'd8, 1'b1, 1'b0);
    tick();
    start = 1'b0;
    chk3("t6.ignstart2", 8'd9, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk3("t6.async", 8'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk3("t6.post", 8'd0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
